// File: rtl/chiplet_array_pkg.sv
// Shared types for the chiplet array performance model: node FSM states and
// the {id, size} workload token layout.
package chiplet_array_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        XFER    = 2'd2,
        OUT     = 2'd3
    } chiplet_state_e;

    localparam int unsigned ID_W_DEF   = 8;
    localparam int unsigned SIZE_W_DEF = 8;

    // Default-width token; wider builds use token_width() for flat vectors.
    typedef struct packed {
        logic [ID_W_DEF-1:0]   id;
        logic [SIZE_W_DEF-1:0] size;
    } token_t;

    function automatic int unsigned token_width(input int unsigned id_w,
                                                input int unsigned size_w);
        return id_w + size_w;
    endfunction

endpackage

// File: rtl/chiplet_array_node.sv
// One chiplet: latches a token, burns compute cycles, then link cycles, then
// offers the unchanged token east. All outputs come straight from flops.
module chiplet_node
    import chiplet_array_pkg::*;
#(
    parameter int unsigned id_width_p      = 8,
    parameter int unsigned size_width_p    = 8,
    parameter int unsigned macs_per_data_p = 4,
    parameter int unsigned num_macs_p      = 4,
    parameter int unsigned bandwidth_p     = 4,
    parameter int unsigned data_bytes_p    = 2
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               v_i,
    input  logic [id_width_p+size_width_p-1:0] data_i,
    output logic                               ready_o,
    output logic                               v_o,
    output logic [id_width_p+size_width_p-1:0] data_o,
    input  logic                               ready_i
);

    localparam int unsigned width_p = id_width_p + size_width_p;

    chiplet_state_e     state_q, state_d;
    logic [31:0]        acc_q, acc_d;
    logic [width_p-1:0] tok_q, tok_d;
    logic               ready_q, ready_d;

    logic [31:0] size_w, work_w, bytes_w, acc_mac, acc_bw;

    assign size_w  = 32'(tok_q[size_width_p-1:0]);
    assign work_w  = size_w * 32'(macs_per_data_p);
    assign bytes_w = size_w * 32'(data_bytes_p);
    assign acc_mac = acc_q + 32'(num_macs_p);
    assign acc_bw  = acc_q + 32'(bandwidth_p);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tok_d   = tok_q;
        unique case (state_q)
            IDLE: begin
                if (v_i && ready_q) begin
                    tok_d   = data_i;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                if (acc_mac >= work_w) begin
                    acc_d   = '0;
                    state_d = XFER;
                end else begin
                    acc_d = acc_mac;
                end
            end
            XFER: begin
                if (acc_bw >= bytes_w) begin
                    acc_d   = '0;
                    state_d = OUT;
                end else begin
                    acc_d = acc_bw;
                end
            end
            OUT: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Ready is a flop that stays low through reset and rises one edge later.
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tok_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tok_q   <= tok_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;
    assign v_o     = (state_q == OUT);
    assign data_o  = tok_q;

endmodule

// File: rtl/chiplet_array.sv
// Grid of chiplet_node: each row is an independent west-to-east pipeline with
// its own row-level ready/valid ports on both edges.
module chiplet_array
    import chiplet_array_pkg::*;
#(
    parameter int unsigned id_width_p         = 8,
    parameter int unsigned size_width_p       = 8,
    parameter int unsigned data_bytes_p       = 2,
    parameter int unsigned num_chiplets_x_p   = 2,
    parameter int unsigned num_chiplets_y_p   = 2,
    parameter int unsigned chiplets_routing_p = 0,
    parameter int unsigned num_macs_p         = 4,
    parameter int unsigned bandwidth_p        = 4,
    parameter int unsigned macs_per_data_p [num_chiplets_x_p-1:0] = '{3, 4}
) (
    input  logic                                                     clk_i,
    input  logic                                                     reset_i,
    output logic [num_chiplets_y_p-1:0]                              ready_o,
    input  logic [num_chiplets_y_p-1:0][id_width_p+size_width_p-1:0] data_i,
    input  logic [num_chiplets_y_p-1:0]                              v_i,
    output logic [num_chiplets_y_p-1:0]                              v_o,
    output logic [num_chiplets_y_p-1:0][id_width_p+size_width_p-1:0] data_o,
    input  logic [num_chiplets_y_p-1:0]                              ready_i
);

    localparam int unsigned width_p = token_width(id_width_p, size_width_p);

    if (chiplets_routing_p != 0) begin : g_bad_routing
        $fatal(1, "chiplet_array: only row-wise routing (0) is supported");
    end

    // Column x drives link x+1; link 0 is the west port, link X the east port.
    logic [num_chiplets_y_p-1:0][num_chiplets_x_p:0]              v_w;
    logic [num_chiplets_y_p-1:0][num_chiplets_x_p:0]              rdy_w;
    logic [num_chiplets_y_p-1:0][num_chiplets_x_p:0][width_p-1:0] tok_w;

    for (genvar y = 0; y < num_chiplets_y_p; y++) begin : g_row
        assign v_w[y][0]                  = v_i[y];
        assign tok_w[y][0]                = data_i[y];
        assign rdy_w[y][num_chiplets_x_p] = ready_i[y];
        assign ready_o[y]                 = rdy_w[y][0];
        assign v_o[y]                     = v_w[y][num_chiplets_x_p];
        assign data_o[y]                  = tok_w[y][num_chiplets_x_p];

        for (genvar x = 0; x < num_chiplets_x_p; x++) begin : g_col
            chiplet_node #(
                .id_width_p     (id_width_p),
                .size_width_p   (size_width_p),
                .macs_per_data_p(macs_per_data_p[x]),
                .num_macs_p     (num_macs_p),
                .bandwidth_p    (bandwidth_p),
                .data_bytes_p   (data_bytes_p)
            ) u_node (
                .clk_i  (clk_i),
                .reset_i(reset_i),
                .v_i    (v_w[y][x]),
                .data_i (tok_w[y][x]),
                .ready_o(rdy_w[y][x]),
                .v_o    (v_w[y][x+1]),
                .data_o (tok_w[y][x+1]),
                .ready_i(rdy_w[y][x+1])
            );
        end
    end

endmodule

// File: tb/tb_chiplet_array.sv
// Randomized and directed checks of chiplet_array against a per-chiplet
// occupancy/countdown reference model.
module tb_chiplet_array;

    localparam int X  = 2;
    localparam int Y  = 2;
    localparam int W  = 16;
    localparam int NM = 4;
    localparam int BW = 4;
    localparam int DB = 2;

    int mpd [X] = '{4, 3};  // MACs per element by column: col0=4, col1=3

    logic                clk_i   = 1'b0;
    logic                reset_i = 1'b1;
    logic [Y-1:0]        ready_o, v_i, v_o, ready_i;
    logic [Y-1:0][W-1:0] data_i, data_o;

    chiplet_array dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .ready_o(ready_o),
        .data_i (data_i),
        .v_i    (v_i),
        .v_o    (v_o),
        .data_o (data_o),
        .ready_i(ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: 0 = empty, 1 = working (countdown), 2 = holding token for east.
    int             ms [Y][X];
    int             mc [Y][X];
    logic [W-1:0]   mt [Y][X];
    bit             armed;

    logic [W-1:0]   oq   [Y][$];
    int             ocyc [Y][$];
    int             acc_cyc [Y];

    function automatic int hop_cost(input int x, input int size);
        int c, t;
        c = (size * mpd[x] + NM - 1) / NM;
        t = (size * DB + BW - 1) / BW;
        if (c < 1) c = 1;
        if (t < 1) t = 1;
        return c + t;
    endfunction

    task automatic model_reset();
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++) begin
                ms[y][x] = 0; mc[y][x] = 0; mt[y][x] = '0;
            end
        armed = 0;
    endtask

    task automatic model_edge();
        int           s [Y][X];
        logic [W-1:0] t [Y][X];
        logic [W-1:0] tk;
        bit           down, up;
        if (!reset_i) begin
            model_reset();
            return;
        end
        s = ms;
        t = mt;
        for (int y = 0; y < Y; y++)
            for (int x = 0; x < X; x++) begin
                down = (x == X-1) ? ready_i[y] : (s[y][x+1] == 0 && armed);
                up   = (x == 0) ? v_i[y] : (s[y][x-1] == 2);
                case (s[y][x])
                    2: if (down) ms[y][x] = 0;
                    1: begin
                        mc[y][x]--;
                        if (mc[y][x] == 0) ms[y][x] = 2;
                    end
                    default: if (up && armed) begin
                        tk = (x == 0) ? data_i[y] : t[y][x-1];
                        ms[y][x] = 1;
                        mt[y][x] = tk;
                        mc[y][x] = hop_cost(x, int'(tk[7:0]));
                    end
                endcase
            end
        armed = 1;
    endtask

    task automatic compare();
        for (int y = 0; y < Y; y++) begin
            check($sformatf("v_o[%0d]", y), 32'(v_o[y]), 32'(ms[y][X-1] == 2));
            check($sformatf("ready_o[%0d]", y), 32'(ready_o[y]), 32'(ms[y][0] == 0 && armed));
            if (ms[y][X-1] == 2)
                check($sformatf("data_o[%0d]", y), 32'(data_o[y]), 32'(mt[y][X-1]));
        end
    endtask

    // One clock: log handshakes seen before the edge, advance model, compare.
    task automatic step();
        logic [Y-1:0]        hs, ac;
        logic [Y-1:0][W-1:0] od;
        hs = v_o & ready_i;
        ac = v_i & ready_o;
        od = data_o;
        @(posedge clk_i);
        cyc++;
        for (int y = 0; y < Y; y++) begin
            if (hs[y]) begin
                oq[y].push_back(od[y]);
                ocyc[y].push_back(cyc);
            end
            if (ac[y]) acc_cyc[y] = cyc;
        end
        model_edge();
        #1;
        compare();
    endtask

    task automatic clear_q();
        for (int y = 0; y < Y; y++) begin
            oq[y].delete();
            ocyc[y].delete();
        end
    endtask

    task automatic send(input int y, input logic [W-1:0] tok);
        int n = 0;
        v_i[y]    = 1'b1;
        data_i[y] = tok;
        while (!ready_o[y] && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) check("send_timeout", 32'(n), 32'(0));
        step();
        v_i[y] = 1'b0;
    endtask

    task automatic wait_out(input int y, input int count, input int limit);
        int n = 0;
        while (oq[y].size() < count && n < limit) begin
            step();
            n++;
        end
        if (oq[y].size() < count) check("wait_out_timeout", 32'(oq[y].size()), 32'(count));
    endtask

    initial begin
        v_i     = '0;
        data_i  = '0;
        ready_i = '1;
        model_reset();
        #1 reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #2;
        check("rst_ready_o", 32'(ready_o), 32'(0));
        check("rst_v_o", 32'(v_o), 32'(0));
        check("rst_data_o", 32'(data_o), 32'(0));
        reset_i = 1'b1;
        step();
        check("rst_release_ready", 32'(ready_o), 32'(2'b11));

        // Single token, size 2: two hops of 4 edges, v_o after edge k+7.
        clear_q();
        send(0, {8'd5, 8'd2});
        wait_out(0, 1, 40);
        check("single_lat", 32'(ocyc[0][0] - acc_cyc[0]), 32'(8));
        check("single_data", 32'(oq[0][0]), 32'({8'd5, 8'd2}));
        check("single_pulse", 32'(v_o[0]), 32'(0));
        repeat (3) step();

        // Size 0: C=T=1 per column, drained 6 edges after accept.
        clear_q();
        send(0, {8'd1, 8'd0});
        wait_out(0, 1, 40);
        check("size0_lat", 32'(ocyc[0][0] - acc_cyc[0]), 32'(6));
        check("size0_data", 32'(oq[0][0]), 32'({8'd1, 8'd0}));

        // Backpressure: fill both columns, col0 stuck in OUT drops ready_o.
        clear_q();
        ready_i[0] = 1'b0;
        send(0, {8'd1, 8'd2});
        send(0, {8'd2, 8'd2});
        repeat (15) step();
        check("bp_ready_low", 32'(ready_o[0]), 32'(0));
        check("bp_no_out", 32'(oq[0].size()), 32'(0));
        ready_i[0] = 1'b1;
        send(0, {8'd3, 8'd2});
        send(0, {8'd4, 8'd2});
        wait_out(0, 4, 100);
        for (int i = 0; i < 4; i++)
            if (i < oq[0].size()) check("bp_order", 32'(oq[0][i]), 32'({8'(i + 1), 8'd2}));
        repeat (10) step();
        check("bp_no_dup", 32'(oq[0].size()), 32'(4));

        // Row independence: big token on row 0, small on row 1, same edge.
        clear_q();
        data_i[0] = {8'd10, 8'd8};
        data_i[1] = {8'd11, 8'd2};
        v_i       = 2'b11;
        step();
        v_i = '0;
        wait_out(0, 1, 60);
        wait_out(1, 1, 60);
        if (ocyc[0].size() > 0 && ocyc[1].size() > 0) begin
            check("row1_first", 32'(ocyc[1][0] < ocyc[0][0]), 32'(1));
            check("row1_lat", 32'(ocyc[1][0] - acc_cyc[1]), 32'(8));
        end

        // Reset while a size-4 token is computing in col0.
        clear_q();
        send(0, {8'd7, 8'd4});
        step();
        #3 reset_i = 1'b0;
        model_reset();
        #1;
        check("midrst_v_o", 32'(v_o), 32'(0));
        check("midrst_ready_o", 32'(ready_o), 32'(0));
        step();
        check("midrst_hold_ready", 32'(ready_o), 32'(0));
        #2 reset_i = 1'b1;
        step();
        check("midrst_release_ready", 32'(ready_o), 32'(2'b11));
        repeat (30) step();
        check("midrst_dropped", 32'(oq[0].size()), 32'(0));

        // Throughput: back-to-back size-2 tokens, one output per 5 cycles.
        clear_q();
        for (int i = 0; i < 8; i++) send(0, {8'(8'h20 + i), 8'd2});
        wait_out(0, 8, 80);
        for (int i = 2; i < 8; i++)
            if (i < ocyc[0].size())
                check("tput_gap", 32'(ocyc[0][i] - ocyc[0][i-1]), 32'(5));

        // Random traffic with random backpressure against the model.
        clear_q();
        for (int n = 0; n < 1500; n++) begin
            for (int y = 0; y < Y; y++) begin
                v_i[y]     = 1'($urandom);
                data_i[y]  = {8'($urandom), 8'($urandom_range(0, 12))};
                ready_i[y] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        v_i     = '0;
        ready_i = '1;
        repeat (60) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
